// File: rtl/mac_issue_pipe.sv
// mac_issue_pipe
//   Issue and retire pipeline wrapped around an external, purely combinational
//   multiply-accumulate core computing T = A + (B * C).
//
//   S0 registers the accepted operands and the effective rounding mode and
//   feeds them straight to the core. S1 captures the core result and flags.
//   S2..S_PARM_STAGES delay that captured result further. Outputs come from
//   the last stage. A request driven before a clock edge therefore shows up on
//   valid_o PARM_STAGES+1 edges later. A single stall_i freezes everything.
//
// Ports
//   clk_i, rst_i           clock; synchronous active-high reset
//   stall_i                freezes every stage and every output
//   req_i / ready_o        request handshake (ready_o = !stall_i && !rst_i)
//   Rounding_mode_i        static rounding mode; all-ones selects frm (DYN)
//   A_i, B_i, C_i          operands
//   frm_we_i, frm_i        dynamic rounding-mode register write port
//   fflags_clr_i           clears the sticky exception flags
//   core_*_o / core_*_i    connection to the combinational MAC core
//   valid_o, Result_o      retiring result
//   NV_o, OF_o, UF_o, NX_o per-operation exception flags
//   rm_err_o               the retiring op used an illegal rounding mode
//   fflags_o               sticky flags {NV, DZ, OF, UF, NX}; DZ is always 0
module mac_issue_pipe #(
  parameter int PARM_XLEN   = 32,
  parameter int PARM_RM     = 3,
  parameter int PARM_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 req_i,
  output logic                 ready_o,
  input  logic [PARM_RM-1:0]   Rounding_mode_i,
  input  logic [PARM_XLEN-1:0] A_i,
  input  logic [PARM_XLEN-1:0] B_i,
  input  logic [PARM_XLEN-1:0] C_i,
  input  logic                 frm_we_i,
  input  logic [PARM_RM-1:0]   frm_i,
  input  logic                 fflags_clr_i,
  output logic [PARM_RM-1:0]   core_rm_o,
  output logic [PARM_XLEN-1:0] core_A_o,
  output logic [PARM_XLEN-1:0] core_B_o,
  output logic [PARM_XLEN-1:0] core_C_o,
  input  logic [PARM_XLEN-1:0] core_result_i,
  input  logic                 core_NV_i,
  input  logic                 core_OF_i,
  input  logic                 core_UF_i,
  input  logic                 core_NX_i,
  output logic                 valid_o,
  output logic [PARM_XLEN-1:0] Result_o,
  output logic                 NV_o,
  output logic                 OF_o,
  output logic                 UF_o,
  output logic                 NX_o,
  output logic                 rm_err_o,
  output logic [4:0]           fflags_o
);

  localparam logic [PARM_RM-1:0]   RM_DYN    = '1;
  localparam logic [PARM_RM-1:0]   RM_RSV5   = PARM_RM'(5);
  localparam logic [PARM_RM-1:0]   RM_RSV6   = PARM_RM'(6);
  localparam logic [PARM_RM-1:0]   RM_RSV7   = PARM_RM'(7);
  localparam logic [PARM_XLEN-1:0] CANON_NAN = PARM_XLEN'(32'h7FC00000);

  logic [PARM_RM-1:0]   frm_q;
  logic [PARM_RM-1:0]   eff_rm;
  logic                 accept;

  logic                 s0_valid;
  logic [PARM_XLEN-1:0] s0_a;
  logic [PARM_XLEN-1:0] s0_b;
  logic [PARM_XLEN-1:0] s0_c;
  logic [PARM_RM-1:0]   s0_rm;
  logic                 s0_rm_illegal;

  // Stage arrays are ordered 1..PARM_STAGES; flags are packed {NV, OF, UF, NX}.
  logic                 st_valid  [1:PARM_STAGES];
  logic [PARM_XLEN-1:0] st_result [1:PARM_STAGES];
  logic [3:0]           st_flags  [1:PARM_STAGES];
  logic                 st_rm_err [1:PARM_STAGES];

  logic [4:0]           fflags_q;
  logic                 retire;
  logic [4:0]           retire_flags;

  assign ready_o = !stall_i && !rst_i;
  assign accept  = req_i && ready_o;

  // DYN reads frm as it stands now, so a same-cycle frm write is not seen.
  assign eff_rm = (Rounding_mode_i == RM_DYN) ? frm_q : Rounding_mode_i;

  assign s0_rm_illegal = s0_valid &&
                         ((s0_rm == RM_RSV5) || (s0_rm == RM_RSV6) || (s0_rm == RM_RSV7));

  assign core_rm_o = s0_rm;
  assign core_A_o  = s0_a;
  assign core_B_o  = s0_b;
  assign core_C_o  = s0_c;

  // frm is architectural state, so writes go through even while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frm_q <= '0;
    end else if (frm_we_i) begin
      frm_q <= frm_i;
    end
  end

  // S0: operands are only reloaded on acceptance; a bubble just drops valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_c     <= '0;
      s0_rm    <= '0;
    end else if (!stall_i) begin
      s0_valid <= accept;
      if (accept) begin
        s0_a  <= A_i;
        s0_b  <= B_i;
        s0_c  <= C_i;
        s0_rm <= eff_rm;
      end
    end
  end

  // S1 samples the core; an illegal rounding mode replaces the result with
  // the canonical quiet NaN and suppresses the core flags. Later stages shift.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i <= PARM_STAGES; i++) begin
        st_valid[i]  <= 1'b0;
        st_result[i] <= '0;
        st_flags[i]  <= '0;
        st_rm_err[i] <= 1'b0;
      end
    end else if (!stall_i) begin
      st_valid[1]  <= s0_valid;
      st_result[1] <= s0_rm_illegal ? CANON_NAN : core_result_i;
      st_flags[1]  <= s0_rm_illegal ? 4'b0000
                                    : {core_NV_i, core_OF_i, core_UF_i, core_NX_i};
      st_rm_err[1] <= s0_rm_illegal;
      for (int i = 2; i <= PARM_STAGES; i++) begin
        st_valid[i]  <= st_valid[i-1];
        st_result[i] <= st_result[i-1];
        st_flags[i]  <= st_flags[i-1];
        st_rm_err[i] <= st_rm_err[i-1];
      end
    end
  end

  assign valid_o  = st_valid[PARM_STAGES];
  assign Result_o = st_result[PARM_STAGES];
  assign NV_o     = st_flags[PARM_STAGES][3];
  assign OF_o     = st_flags[PARM_STAGES][2];
  assign UF_o     = st_flags[PARM_STAGES][1];
  assign NX_o     = st_flags[PARM_STAGES][0];
  assign rm_err_o = st_rm_err[PARM_STAGES];

  // A result held under stall is not a retirement; it retires on the edge
  // where stall is finally low.
  assign retire       = valid_o && !stall_i;
  assign retire_flags = {NV_o, 1'b0, OF_o, UF_o, NX_o};

  // Clear applies first so a same-cycle retirement still lands its flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else if (retire) begin
      fflags_q <= (fflags_clr_i ? 5'b00000 : fflags_q) | retire_flags;
    end else if (fflags_clr_i) begin
      fflags_q <= '0;
    end
  end

  assign fflags_o = fflags_q;

endmodule

// File: tb/tb_mac_issue_pipe.sv
// tb_mac_issue_pipe
//   Self-checking bench for mac_issue_pipe with default parameters.
//   The bench plays the role of the combinational core: the result is the
//   integer A + B*C (with one fixed float vector mapped to 40E00000), and the
//   core flags are taken from core_A_o[3:0] as {NV, OF, UF, NX} so each op
//   carries its own flag pattern through the pipe.
module tb_mac_issue_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        req_i;
  logic        ready_o;
  logic [2:0]  Rounding_mode_i;
  logic [31:0] A_i, B_i, C_i;
  logic        frm_we_i;
  logic [2:0]  frm_i;
  logic        fflags_clr_i;
  logic [2:0]  core_rm_o;
  logic [31:0] core_A_o, core_B_o, core_C_o;
  logic [31:0] core_result_i;
  logic        core_NV_i, core_OF_i, core_UF_i, core_NX_i;
  logic        valid_o;
  logic [31:0] Result_o;
  logic        NV_o, OF_o, UF_o, NX_o;
  logic        rm_err_o;
  logic [4:0]  fflags_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  mac_issue_pipe #(.PARM_XLEN(32), .PARM_RM(3), .PARM_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .req_i(req_i),
    .ready_o(ready_o), .Rounding_mode_i(Rounding_mode_i),
    .A_i(A_i), .B_i(B_i), .C_i(C_i),
    .frm_we_i(frm_we_i), .frm_i(frm_i), .fflags_clr_i(fflags_clr_i),
    .core_rm_o(core_rm_o), .core_A_o(core_A_o), .core_B_o(core_B_o),
    .core_C_o(core_C_o), .core_result_i(core_result_i),
    .core_NV_i(core_NV_i), .core_OF_i(core_OF_i), .core_UF_i(core_UF_i),
    .core_NX_i(core_NX_i), .valid_o(valid_o), .Result_o(Result_o),
    .NV_o(NV_o), .OF_o(OF_o), .UF_o(UF_o), .NX_o(NX_o),
    .rm_err_o(rm_err_o), .fflags_o(fflags_o)
  );

  function automatic logic [31:0] core_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
    if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h40400000)
      return 32'h40E00000;
    return a + b * c;
  endfunction

  assign core_result_i = core_model(core_A_o, core_B_o, core_C_o);
  assign core_NV_i     = core_A_o[3];
  assign core_OF_i     = core_A_o[2];
  assign core_UF_i     = core_A_o[1];
  assign core_NX_i     = core_A_o[0];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [2:0]  rm;
    logic [2:0]  exp_rm;
    logic [31:0] exp_result;
    logic [3:0]  exp_flags;
    logic        exp_rm_err;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Presents one request for a single edge, reports the core_rm_o seen after
  // acceptance, then waits (bounded) for valid_o and reports the edge count.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [2:0] rm,
                               output logic [2:0] rm_seen, output int cycles);
    req_i = 1'b1; A_i = a; B_i = b; C_i = c; Rounding_mode_i = rm;
    tick();
    req_i = 1'b0;
    rm_seen = core_rm_o;
    cycles = 1;
    while (!valid_o && cycles < 10) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    logic [2:0] rm_seen;
    int         cycles;
    logic [4:0] exp_fflags;
    logic [31:0] seq_a   [4];
    logic [31:0] seq_exp [4];
    int         issued, retired, no_valid;
    logic       held_valid;
    logic [31:0] held_result;
    logic       req_now;

    vecs[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 3'b000, 3'b000, 32'h40E00000, 4'b0000, 1'b0};
    vecs[1] = '{32'h00000010, 32'd3,        32'd5,        3'b001, 3'b001, 32'h0000001F, 4'b0000, 1'b0};
    vecs[2] = '{32'h00000001, 32'd2,        32'd2,        3'b010, 3'b010, 32'h00000005, 4'b0001, 1'b0};
    vecs[3] = '{32'h0000000F, 32'd0,        32'd7,        3'b100, 3'b100, 32'h0000000F, 4'b1111, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'd10,       32'd10,       3'b011, 3'b011, 32'h00000063, 4'b1111, 1'b0};
    vecs[5] = '{32'h00000002, 32'd1,        32'd1,        3'b101, 3'b101, 32'h7FC00000, 4'b0000, 1'b1};
    vecs[6] = '{32'h00000003, 32'd1,        32'd1,        3'b110, 3'b110, 32'h7FC00000, 4'b0000, 1'b1};
    vecs[7] = '{32'h00000004, 32'd4,        32'd4,        3'b111, 3'b000, 32'h00000014, 4'b0100, 1'b0};

    rst_i = 1'b1; stall_i = 1'b0; req_i = 1'b0; Rounding_mode_i = 3'b000;
    A_i = '0; B_i = '0; C_i = '0; frm_we_i = 1'b0; frm_i = 3'b000; fflags_clr_i = 1'b0;
    tick();
    tick();
    checkOutput("reset_ready", {31'b0, ready_o}, 32'd0);
    checkOutput("reset_valid", {31'b0, valid_o}, 32'd0);
    checkOutput("reset_result", Result_o, 32'd0);
    checkOutput("reset_fflags", {27'b0, fflags_o}, 32'd0);
    checkOutput("reset_core_a", core_A_o, 32'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("ready_idle", {31'b0, ready_o}, 32'd1);

    $display("[TB] table vectors");
    exp_fflags = 5'b00000;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].rm, rm_seen, cycles);
      checkOutput($sformatf("v%0d_core_rm", i), {29'b0, rm_seen}, {29'b0, vecs[i].exp_rm});
      checkOutput($sformatf("v%0d_latency", i), cycles, 32'd3);
      checkOutput($sformatf("v%0d_result", i), Result_o, vecs[i].exp_result);
      checkOutput($sformatf("v%0d_flags", i), {28'b0, NV_o, OF_o, UF_o, NX_o},
                  {28'b0, vecs[i].exp_flags});
      checkOutput($sformatf("v%0d_rm_err", i), {31'b0, rm_err_o}, {31'b0, vecs[i].exp_rm_err});
      exp_fflags = exp_fflags | {vecs[i].exp_flags[3], 1'b0, vecs[i].exp_flags[2:0]};
      tick();
      checkOutput($sformatf("v%0d_fflags", i), {27'b0, fflags_o}, {27'b0, exp_fflags});
      checkOutput($sformatf("v%0d_valid_drop", i), {31'b0, valid_o}, 32'd0);
    end

    $display("[TB] dynamic rounding mode");
    frm_we_i = 1'b1; frm_i = 3'b011;
    tick();
    frm_we_i = 1'b0;
    req_i = 1'b1; A_i = 32'h20; B_i = 32'd1; C_i = 32'd1; Rounding_mode_i = 3'b111;
    tick();
    checkOutput("dyn_core_rm", {29'b0, core_rm_o}, 32'd3);
    frm_we_i = 1'b1; frm_i = 3'b101; A_i = 32'h30;
    tick();
    frm_we_i = 1'b0; req_i = 1'b0;
    checkOutput("dyn_old_frm", {29'b0, core_rm_o}, 32'd3);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(32'h00000008, 32'd1, 32'd1, 3'b111, rm_seen, cycles);
    checkOutput("dyn_ill_core_rm", {29'b0, rm_seen}, 32'd5);
    checkOutput("dyn_ill_latency", cycles, 32'd3);
    checkOutput("dyn_ill_result", Result_o, 32'h7FC00000);
    checkOutput("dyn_ill_rm_err", {31'b0, rm_err_o}, 32'd1);
    checkOutput("dyn_ill_nv", {31'b0, NV_o}, 32'd0);
    tick();

    $display("[TB] sticky flags with clear");
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    checkOutput("clr_no_retire", {27'b0, fflags_o}, 32'd0);
    req_i = 1'b1; A_i = 32'h1; B_i = 32'd0; C_i = 32'd0; Rounding_mode_i = 3'b000;
    tick();
    A_i = 32'h4;
    tick();
    req_i = 1'b0;
    tick();
    checkOutput("op1_result", Result_o, 32'h1);
    tick();
    checkOutput("op1_fflags", {27'b0, fflags_o}, 32'b00001);
    checkOutput("op2_result", Result_o, 32'h4);
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    checkOutput("op2_fflags_clr", {27'b0, fflags_o}, 32'b00100);

    $display("[TB] back-to-back with stall");
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    seq_a[0] = 32'h100; seq_a[1] = 32'h200; seq_a[2] = 32'h302; seq_a[3] = 32'h400;
    for (int i = 0; i < 4; i++) seq_exp[i] = seq_a[i] + 32'(i + 1);
    issued = 0; retired = 0;
    for (int k = 0; k < 20; k++) begin
      stall_i = (k == 3 || k == 4);
      req_now = (issued < 4) && !stall_i;
      req_i = req_now;
      A_i = seq_a[issued < 4 ? issued : 3]; B_i = 32'd1; C_i = 32'(issued + 1);
      Rounding_mode_i = 3'b000;
      #1;
      if (k == 3) checkOutput("stall_ready", {31'b0, ready_o}, 32'd0);
      if (valid_o && !stall_i) begin
        if (retired < 4) checkOutput($sformatf("seq_ret%0d", retired), Result_o, seq_exp[retired]);
        else checkOutput("seq_extra_retire", 32'(retired), 32'd4);
        retired++;
      end
      held_valid = valid_o; held_result = Result_o;
      tick();
      if (stall_i) begin
        checkOutput($sformatf("hold_valid_k%0d", k), {31'b0, valid_o}, {31'b0, held_valid});
        checkOutput($sformatf("hold_result_k%0d", k), Result_o, held_result);
      end
      if (req_now) issued++;
    end
    stall_i = 1'b0; req_i = 1'b0;
    checkOutput("seq_retired", retired, 32'd4);
    checkOutput("seq_fflags", {27'b0, fflags_o}, 32'b00010);

    $display("[TB] reset with ops in flight");
    req_i = 1'b1; A_i = 32'h501; B_i = 32'd1; C_i = 32'd1; Rounding_mode_i = 3'b000;
    tick();
    A_i = 32'h602;
    tick();
    rst_i = 1'b1; frm_we_i = 1'b1; frm_i = 3'b011; fflags_clr_i = 1'b0; stall_i = 1'b1;
    #1;
    checkOutput("rst_ready", {31'b0, ready_o}, 32'd0);
    tick();
    rst_i = 1'b0; frm_we_i = 1'b0; req_i = 1'b0; stall_i = 1'b0;
    checkOutput("rst_valid", {31'b0, valid_o}, 32'd0);
    checkOutput("rst_result", Result_o, 32'd0);
    checkOutput("rst_core_a", core_A_o, 32'd0);
    checkOutput("rst_fflags", {27'b0, fflags_o}, 32'd0);
    no_valid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid_o) no_valid++;
    end
    checkOutput("rst_no_valid", no_valid, 32'd0);
    applyStimulus(32'h00000010, 32'd2, 32'd3, 3'b111, rm_seen, cycles);
    checkOutput("post_rst_frm", {29'b0, rm_seen}, 32'd0);
    checkOutput("post_rst_latency", cycles, 32'd3);
    checkOutput("post_rst_result", Result_o, 32'h16);
    tick();

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
